// File: rtl/mdu_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } mdu_op_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result_c
);

  // Negate when requested; the most negative value maps onto itself.
  assign result_c = negate ? W'(~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_seq.sv
// Sequential WIDTH-bit multiply/divide unit, one bit per cycle, results on hi/lo.
// Signed by default; defining MULTDIV_UNSIGNED_EN adds an is_unsigned input (multu/divu).
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  mdu_state_e       state_q, state_nxt;
  mdu_op_e          op_q;
  logic             sign_a_q, neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             busy_nxt, done_nxt, div_zero_nxt;

  logic             use_sign_c, sign_a_c, sign_b_c, start_any_c, div_by_zero_c;
  mdu_op_e          op_sel_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic [WIDTH:0]   mult_sum_c, mult_upper_c, rem_sh_c, diff_c;
  logic [WIDTH-1:0] iter_hi_c, iter_lo_c;
  logic [DW-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

`ifdef MULTDIV_UNSIGNED_EN
  assign use_sign_c = ~is_unsigned;
`else
  assign use_sign_c = 1'b1;
`endif

  assign sign_a_c      = use_sign_c & op_a[WIDTH-1];
  assign sign_b_c      = use_sign_c & op_b[WIDTH-1];
  assign start_any_c   = start_mult | start_div;
  assign op_sel_c      = start_mult ? OP_MULT : OP_DIV;
  assign div_by_zero_c = ~start_mult & start_div & (op_b == '0);

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.value(op_a), .negate(sign_a_c), .result_c(abs_a_c));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.value(op_b), .negate(sign_b_c), .result_c(abs_b_c));
  mdu_sign_fix #(.W(DW))    u_fix_prod (.value({acc_hi_q, acc_lo_q}), .negate(neg_q),
                                        .result_c(prod_fix_c));
  mdu_sign_fix #(.W(WIDTH)) u_fix_quo (.value(acc_lo_q), .negate(neg_q), .result_c(quo_fix_c));
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.value(acc_hi_q), .negate(sign_a_q), .result_c(rem_fix_c));

  // One iteration step: shift-add for multiply, restoring trial-subtract for divide.
  always_comb begin
    mult_sum_c   = {1'b0, acc_hi_q} + {1'b0, opnd_q};
    mult_upper_c = acc_lo_q[0] ? mult_sum_c : {1'b0, acc_hi_q};
    rem_sh_c     = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff_c       = rem_sh_c - {1'b0, opnd_q};
    iter_hi_c    = acc_hi_q;
    iter_lo_c    = acc_lo_q;
    if (op_q == OP_MULT) begin
      iter_hi_c = mult_upper_c[WIDTH:1];
      iter_lo_c = {mult_upper_c[0], acc_lo_q[WIDTH-1:1]};
    end else if (!diff_c[WIDTH]) begin
      iter_hi_c = diff_c[WIDTH-1:0];
      iter_lo_c = {acc_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      iter_hi_c = rem_sh_c[WIDTH-1:0];
      iter_lo_c = {acc_lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state_q;
    div_zero_nxt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_any_c) begin
          state_nxt    = div_by_zero_c ? DONE : ITER;
          div_zero_nxt = div_by_zero_c;
        end
      end
      ITER:    if (cnt_q == CNT_W'(1)) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // State and status output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  // Operand capture, iteration datapath and hi/lo result load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_any_c && !div_by_zero_c) begin
            op_q     <= op_sel_c;
            sign_a_q <= sign_a_c;
            neg_q    <= sign_a_c ^ sign_b_c;
            cnt_q    <= CNT_W'(WIDTH);
            acc_hi_q <= '0;
            acc_lo_q <= (op_sel_c == OP_MULT) ? abs_b_c : abs_a_c;
            opnd_q   <= (op_sel_c == OP_MULT) ? abs_a_c : abs_b_c;
          end
        end
        ITER: begin
          cnt_q    <= cnt_q - CNT_W'(1);
          acc_hi_q <= iter_hi_c;
          acc_lo_q <= iter_lo_c;
        end
        SIGN: begin
          if (op_q == OP_MULT) begin
            hi <= prod_fix_c[DW-1:WIDTH];
            lo <= prod_fix_c[WIDTH-1:0];
          end else begin
            hi <= rem_fix_c;
            lo <= quo_fix_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: driver pushes expected hi/lo, monitor checks on done.
module tb_mult_div_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mult_div_seq dut (
    .clock      (clock),
    .reset      (reset),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned(1'b0),
`endif
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the unit signals done.
  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual hi=%h lo=%h expected no done", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_div_zero"}, 64'(div_zero), 64'(e.dz));
      end
    end
    if (reset && div_zero && !done) begin
      checks++;
      failures++;
      $display("FAIL div_zero_without_done actual=1 expected=0");
    end
  end

  // Issue one operation, measure edges to done, check busy window and idle afterwards.
  task automatic do_op(input string name, input logic sm, input logic sd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int elat, input int pulse_at);
    int  n;
    bit  busy_ok;
    exp_t e;
    e.name = name; e.hi = ehi; e.lo = elo; e.dz = edz;
    exp_q.push_back(e);
    @(negedge clock);
    start_mult = sm; start_div = sd; op_a = a; op_b = b;
    @(posedge clock);
    #1 start_mult = 1'b0; start_div = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
    n = 1;
    busy_ok = 1'b1;
    forever begin
      @(negedge clock);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) break;
      if (n >= 100) break;
      if (n == pulse_at) start_div = 1'b1;
      @(posedge clock);
      #1 start_div = 1'b0;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(elat));
    chk({name, "_busy_window"}, 64'(busy_ok), 64'(1));
    @(negedge clock);
    chk({name, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int done_cnt;

    #23;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_div_zero", 64'(div_zero), 64'(0));
    chk("reset_hilo", {hi, lo}, 64'(0));
    @(negedge clock);
    reset = 1'b1;

    do_op("mult_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34, 0);
    do_op("mult_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 34, 0);
    do_op("mult_m1_m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 0, 34, 0);
    do_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34, 0);
    do_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 34, 0);
    do_op("div_100_m7", 0, 1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0, 34, 0);
    do_op("div_m100_7", 0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0, 34, 0);
    do_op("div_setup", 0, 1, 32'h451, 32'h20, 32'h11, 32'h22, 0, 34, 0);
    do_op("div_zero", 0, 1, 32'd5, 32'd0, 32'h11, 32'h22, 1, 1, 0);
    do_op("both_starts", 1, 1, 32'd6, 32'd7, 32'h0, 32'h2A, 0, 34, 10);

    done_cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
    end
    chk("no_extra_done", 64'(done_cnt), 64'(0));

    // Reset mid-iteration: everything clears asynchronously, operation discarded.
    @(negedge clock);
    start_mult = 1'b1; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    @(posedge clock);
    #1 start_mult = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    chk("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy), 64'(0));
    chk("async_reset_done", 64'(done), 64'(0));
    chk("async_reset_hilo", {hi, lo}, 64'(0));
    @(negedge clock);
    reset = 1'b1;

    do_op("mult_after_reset", 1, 0, 32'h0001_2345, 32'h10, 32'h0, 32'h0012_3450, 0, 34, 0);

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
